// File: rtl/alu_op_scheduler_if.sv
// rtl/alu_op_scheduler_if.sv - requester, ALU and response bus bundle for alu_op_scheduler
interface alu_op_scheduler_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*4-1:0] req_op;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_op;
    logic [W-1:0]      alu_y;
    logic              alu_cout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_y;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;

    // slave is the scheduler side, master is the requester/ALU/consumer side
    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_y, alu_cout, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_cout, rsp_id
    );
    modport master (
        output req_valid, req_a, req_b, req_op, alu_y, alu_cout, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_y, rsp_cout, rsp_id
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - round-robin sharing of one fixed-latency ALU; optional ALU_PARITY_CHECK_EN
module alu_op_scheduler #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int ALU_LAT = 3,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_scheduler_if.slave bus,
`ifdef ALU_PARITY_CHECK_EN
    input  logic              alu_par,
    output logic              par_err,
`endif
    output logic              busy
);
    localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   alu_a_q, alu_b_q;
    logic [3:0]     alu_op_q;
    logic [W-1:0]   rsp_y_q;
    logic           rsp_cout_q;
    logic [IDW-1:0] rsp_id_q;

    logic           grant_vld;
    logic [IDW-1:0] grant;
    logic           accept;
    logic           capture;
    int             idx;

    // first valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_vld && bus.req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

    assign accept  = (state_q == S_IDLE) && grant_vld;
    assign capture = (state_q == S_WAIT) && (cnt_q == CW'(1));

    always_comb begin
        bus.req_ready = '0;
        if (!rst && accept) bus.req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_y_q    <= '0;
            rsp_cout_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    alu_a_q  <= bus.req_a[int'(grant)*W +: W];
                    alu_b_q  <= bus.req_b[int'(grant)*W +: W];
                    alu_op_q <= bus.req_op[int'(grant)*4 +: 4];
                    rsp_id_q <= grant;
                    rr_ptr_q <= (int'(grant) == NREQ - 1) ? '0 : grant + IDW'(1);
                    cnt_q    <= CW'(ALU_LAT);
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (capture) begin
                        rsp_y_q    <= bus.alu_y;
                        rsp_cout_q <= bus.alu_cout;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: if (bus.rsp_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_PARITY_CHECK_EN
    logic par_err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err_q <= 1'b0;
        else if (capture && (alu_par != ^{bus.alu_cout, bus.alu_y}))
            par_err_q <= 1'b1;
    end
    assign par_err = par_err_q;
`endif

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.rsp_id    = rsp_id_q;
    assign busy          = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - randomized self-checking bench for alu_op_scheduler
module tb_alu_op_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    always #5 clk = ~clk;

    alu_op_scheduler_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

`ifdef ALU_PARITY_CHECK_EN
    logic alu_par, par_err;
    logic par_corrupt = 1'b0;
`endif

    alu_op_scheduler #(.NREQ(NREQ), .W(W), .ALU_LAT(LAT), .IDW(IDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
`ifdef ALU_PARITY_CHECK_EN
        .alu_par (alu_par),
        .par_err (par_err),
`endif
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rr_m   = 0;
    logic [W-1:0] ma [NREQ];
    logic [W-1:0] mb [NREQ];
    logic [3:0]   mo [NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W:0] alu_fn(logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
        case (op)
            4'd0:    return {1'b0, a & b};
            4'd1:    return {1'b0, a} + {1'b0, b};
            4'd2:    return {1'b0, a} - {1'b0, b};
            4'd3:    return {1'b0, a ^ b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    always_comb {bus.alu_cout, bus.alu_y} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);
`ifdef ALU_PARITY_CHECK_EN
    assign alu_par = par_corrupt ? ~(^{bus.alu_cout, bus.alu_y}) : ^{bus.alu_cout, bus.alu_y};
`endif

    function automatic int pick(logic [NREQ-1:0] m, int p);
        for (int k = 0; k < NREQ; k++)
            if (m[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] op);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_op[i*4 +: 4] = op;
        ma[i] = a; mb[i] = b; mo[i] = op;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, '0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rr_m = 0;
        tick();
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // checks the response currently presented against the model for requester g
    task automatic check_rsp(string tag, int g, int n);
        logic [W:0] e;
        e = alu_fn(ma[g], mb[g], mo[g]);
        checks++;
        if (bus.rsp_valid !== 1'b1 || n != LAT) begin
            errors++;
            $display("FAIL %s latency: valid=%b cycles=%0d expected valid=1 cycles=%0d", tag, bus.rsp_valid, n, LAT);
        end
        checks++;
        if ({bus.rsp_cout, bus.rsp_y} !== e || bus.rsp_id !== IDW'(g)) begin
            errors++;
            $display("FAIL %s result: y=%h cout=%b id=%0d expected y=%h cout=%b id=%0d",
                     tag, bus.rsp_y, bus.rsp_cout, bus.rsp_id, e[W-1:0], e[W], g);
        end
    endtask

    task automatic test_reset();
        do_reset();
        set_req(1, 8'hA5, 8'h5A, 4'd3);
        bus.req_valid = 4'b0010;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, bus.rsp_valid, bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_op,
             bus.rsp_y, bus.rsp_cout, bus.rsp_id} !== '0) begin
            errors++;
            $display("FAIL reset_async: busy=%b rsp_valid=%b req_ready=%b alu_a=%h expected all zero",
                     busy, bus.rsp_valid, bus.req_ready, bus.alu_a);
        end
`ifdef ALU_PARITY_CHECK_EN
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_par_err: got %b expected 0", par_err);
        end
`endif
        bus.req_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b req_ready=%b expected 0/0", busy, bus.req_ready);
        end
    endtask

    task automatic test_single_op();
        int n;
        do_reset();
        set_req(2, 8'h3C, 8'h0F, 4'h1);
        bus.req_valid = 4'b0100;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b expected 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < LAT; k++) begin
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 8'h3C || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_wait k=%0d: rsp_valid=%b alu_a=%h busy=%b expected 0/3c/1",
                         k, bus.rsp_valid, bus.alu_a, busy);
            end
            tick();
        end
        n = LAT;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 8'h4B || bus.rsp_cout !== 1'b0 || bus.rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL single_rsp: valid=%b y=%h cout=%b id=%0d expected 1/4b/0/2",
                     bus.rsp_valid, bus.rsp_y, bus.rsp_cout, bus.rsp_id);
        end
        check_rsp("single_model", 2, n);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || bus.alu_a !== 8'h3C) begin
            errors++;
            $display("FAIL single_done: busy=%b alu_a=%h expected 0/3c", busy, bus.alu_a);
        end
    endtask

    task automatic test_round_robin();
        int n, m, g, last;
        logic [NREQ-1:0] er;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom), 4'($urandom_range(0, 4)));
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        last = 0;
        #1;
        for (int r = 0; r < 5; r++) begin
            m = 0;
            while (bus.req_ready === '0 && m < 20) begin
                tick();
                m++;
            end
            g = r % NREQ;
            er = NREQ'(1) << g;
            checks++;
            if (bus.req_ready !== er || pick(bus.req_valid, rr_m) != g) begin
                errors++;
                $display("FAIL rr_grant %0d: req_ready=%b expected %b", r, bus.req_ready, er);
            end
            tick();
            if (r > 0) begin
                checks++;
                if (cyc - last != LAT + 2) begin
                    errors++;
                    $display("FAIL rr_spacing %0d: got %0d cycles expected %0d", r, cyc - last, LAT + 2);
                end
            end
            last = cyc;
            rr_m = (g + 1) % NREQ;
            wait_rsp(n);
            check_rsp("rr", g, n);
        end
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int n, g, g2;
        logic [NREQ-1:0] mask;
        logic [W:0] e;
        do_reset();
        mask = 4'b1010;
        for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom), 4'($urandom_range(0, 4)));
        bus.req_valid = mask;
        g = pick(mask, rr_m);
        tick();
        rr_m = (g + 1) % NREQ;
        wait_rsp(n);
        check_rsp("bp", g, n);
        e = alu_fn(ma[g], mb[g], mo[g]);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus.rsp_valid !== 1'b1 || {bus.rsp_cout, bus.rsp_y} !== e || bus.rsp_id !== IDW'(g)
                || busy !== 1'b1 || bus.req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold %0d: valid=%b y=%h id=%0d busy=%b req_ready=%b expected 1/%h/%0d/1/0",
                         k, bus.rsp_valid, bus.rsp_y, bus.rsp_id, busy, bus.req_ready, e[W-1:0], g);
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        g2 = pick(mask, rr_m);
        checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== (NREQ'(1) << g2)) begin
            errors++;
            $display("FAIL bp_release: busy=%b valid=%b req_ready=%b expected 0/0/%b",
                     busy, bus.rsp_valid, bus.req_ready, NREQ'(1) << g2);
        end
        tick();
        rr_m = (g2 + 1) % NREQ;
        bus.req_valid = '0;
        wait_rsp(n);
        check_rsp("bp_next", g2, n);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        do_reset();
        set_req(2, 8'h11, 8'h22, 4'd1);
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = '0;
        tick();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        rr_m = 0;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.rsp_valid === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midwait_lost: %0d cycles busy or valid, expected 0", seen);
        end
        bus.req_valid = '1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midwait_first_grant: got %b expected 0001", bus.req_ready);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
    endtask

    task automatic test_random();
        int n, g, hold;
        logic [NREQ-1:0] mask;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            mask = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, W'($urandom), W'($urandom), 4'($urandom_range(0, 7)));
            bus.req_valid = mask;
            #1;
            g = pick(mask, rr_m);
            checks++;
            if (bus.req_ready !== ((g < 0) ? '0 : (NREQ'(1) << g))) begin
                errors++;
                $display("FAIL rand_grant it=%0d: mask=%b req_ready=%b expected grant %0d", it, mask, bus.req_ready, g);
            end
            tick();
            if (g < 0) continue;
            rr_m = (g + 1) % NREQ;
            bus.req_valid = NREQ'($urandom);
            bus.req_a = (NREQ*W)'({$urandom, $urandom});
            bus.req_op = (NREQ*4)'($urandom);
            wait_rsp(n);
            check_rsp("rand", g, n);
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) tick();
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

`ifdef ALU_PARITY_CHECK_EN
    task automatic test_parity();
        int n;
        do_reset();
        par_corrupt = 1'b1;
        set_req(0, 8'h01, 8'h00, 4'd1);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        wait_rsp(n);
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL par_set: got %b expected 1", par_err);
        end
        par_corrupt = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = '0;
        wait_rsp(n);
        tick();
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL par_sticky: got %b expected 1", par_err);
        end
        bus.rsp_ready = 1'b0;
        do_reset();
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL par_clear: got %b expected 0", par_err);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
`ifdef ALU_PARITY_CHECK_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
